// File: rtl/stdp_lut_pkg.sv
// Shared constants for the STDP exponential weight-update lookup:
// dt window, magnitude table, magnitude width and sign encoding.
package stdp_lut_pkg;

    localparam int unsigned DT_MIN = 2;
    localparam int unsigned DT_MAX = 20;
    localparam int          MAG_W  = 9;
    localparam int          N_MAG  = DT_MAX - DT_MIN + 1;
    localparam int          IDX_W  = $clog2(N_MAG);

    // Mode of a synapse update request.
    typedef enum logic {
        SIGN_MINUS = 1'b0,
        SIGN_PLUS  = 1'b1
    } sign_e;

    // MAG[i] is the magnitude for dt = DT_MIN + i.
    // Listed from dt=20 (highest index) down to dt=2 (index 0).
    localparam logic [N_MAG-1:0][MAG_W-1:0] MAG = {
        9'd9,   9'd10,  9'd13,  9'd16,  9'd20,
        9'd24,  9'd29,  9'd36,  9'd44,  9'd54,
        9'd66,  9'd81,  9'd99,  9'd121, 9'd148,
        9'd180, 9'd220, 9'd269, 9'd329
    };

    // Magnitude for any dt; zero outside the DT_MIN..DT_MAX window.
    function automatic logic [MAG_W-1:0] mag_of(input int unsigned dt);
        logic [MAG_W-1:0] m;
        m = '0;
        if (dt >= DT_MIN && dt <= DT_MAX) begin
            m = MAG[IDX_W'(dt - DT_MIN)];
        end
        return m;
    endfunction

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among asserted requests, searching
// from the rotating pointer. The pointer moves past the winner only when
// a grant is actually issued.
module stdp_rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req_i,
    input  logic            en_i,
    output logic [N_CH-1:0] grant_o
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [N_CH-1:0] grant;
    logic [PW-1:0]   idx;
    logic            found;

    // First requester at or after ptr (wrapping at N_CH-1) wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = PW'((int'(ptr_q) + k) % N_CH);
            if (!found && en_i && req_i[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = PW'((int'(idx) + 1) % N_CH);
            end
        end
    end

    // Pointer register; any grant is an accept since grants only go to requesters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o = grant;

endmodule

// File: rtl/stdp_exp_lut_arb.sv
// Shared STDP weight-update lookup: round-robin accept of per-channel
// requests into stage 1, then table lookup and sign application into
// the output register. One lookup per cycle with output backpressure.
module stdp_exp_lut_arb
    import stdp_lut_pkg::*;
#(
    parameter int W    = 24,
    parameter int DT_W = 8,
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req_valid,
    input  logic [N_CH*DT_W-1:0] req_dt,
    input  logic [N_CH-1:0]      req_sign,
    output logic [N_CH-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CH_W-1:0]      rsp_ch,
    output logic [W-1:0]         rsp_val
);

    logic [DT_W-1:0] dt_arr [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_dt_split
            assign dt_arr[gi] = req_dt[gi*DT_W +: DT_W];
        end
    endgenerate

    logic            s1_valid_q, s1_valid_d;
    logic [CH_W-1:0] s1_ch_q, s1_ch_d;
    logic [DT_W-1:0] s1_dt_q, s1_dt_d;
    logic            s1_sign_q, s1_sign_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [CH_W-1:0] rsp_ch_q, rsp_ch_d;
    logic [W-1:0]    rsp_val_q, rsp_val_d;

    logic            adv;
    logic            s1_free;
    logic            arb_en;
    logic [N_CH-1:0] grant;
    logic            accept;

    logic [CH_W-1:0] sel_ch;
    logic [DT_W-1:0] sel_dt;
    logic            sel_sign;

    logic [MAG_W-1:0] mag;
    logic [W-1:0]     mag_ext;
    logic [W-1:0]     lut_val;

    // Output register frees when empty or being consumed; stage 1 frees when
    // empty or moving forward. Grants are suppressed while held in reset.
    assign adv     = !rsp_valid_q || rsp_ready;
    assign s1_free = !s1_valid_q || adv;
    assign arb_en  = s1_free && rst;

    stdp_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_valid),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // Route the granted channel's request fields.
    always_comb begin
        sel_ch   = '0;
        sel_dt   = '0;
        sel_sign = SIGN_MINUS;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_ch   = CH_W'(i);
                sel_dt   = dt_arr[i];
                sel_sign = req_sign[i];
            end
        end
    end

    // Stage 1 next state: latch on accept, drain when advancing without one.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_dt_d    = s1_dt_q;
        s1_sign_d  = s1_sign_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_ch_d    = sel_ch;
            s1_dt_d    = sel_dt;
            s1_sign_d  = sel_sign;
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_dt_q    <= '0;
            s1_sign_q  <= SIGN_MINUS;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_dt_q    <= s1_dt_d;
            s1_sign_q  <= s1_sign_d;
        end
    end

    // Table lookup and sign; negating a zero magnitude still gives zero.
    always_comb begin
        mag     = mag_of(32'(s1_dt_q));
        mag_ext = W'(mag);
        lut_val = (s1_sign_q == SIGN_PLUS) ? mag_ext : (~mag_ext + W'(1));
    end

    // Output next state: load the stage-1 result whenever the pipe advances.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_ch_d    = rsp_ch_q;
        rsp_val_d   = rsp_val_q;
        if (adv) begin
            rsp_valid_d = s1_valid_q;
            rsp_ch_d    = s1_ch_q;
            rsp_val_d   = lut_val;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_val_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_val_q   <= rsp_val_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_ch    = rsp_ch_q;
    assign rsp_val   = rsp_val_q;

endmodule

// File: tb/tb_stdp_exp_lut_arb.sv
// Bench for stdp_exp_lut_arb: directed vector table, round-robin,
// backpressure, sparse fairness, mid-flight reset and random traffic
// against a transaction-level reference model with an in-order scoreboard.
module tb_stdp_exp_lut_arb;

    localparam int W    = 24;
    localparam int DT_W = 8;
    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic                 clk;
    logic                 rst;
    logic [N_CH-1:0]      req_valid;
    logic [N_CH*DT_W-1:0] req_dt;
    logic [N_CH-1:0]      req_sign;
    logic [N_CH-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CH_W-1:0]      rsp_ch;
    logic [W-1:0]         rsp_val;

    stdp_exp_lut_arb #(
        .W    (W),
        .DT_W (DT_W),
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_dt    (req_dt),
        .req_sign  (req_sign),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ch    (rsp_ch),
        .rsp_val   (rsp_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int val;
    } item_t;

    typedef struct {
        int ch;
        int dt;
        int sgn;
        int val;
    } vec_t;

    item_t exp_q[$];
    int    grant_log[$];
    int    n_checks;
    int    n_errors;
    int    ptr_m;
    bit    s1_full;
    bit    out_full;
    int    cycle;
    int    last_ch;
    int    last_val;
    int    last_rsp_cycle;
    int    last_acc_cycle;
    int    mag_ref [0:20];
    vec_t  vecs [10];

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cycle);
        end
    endtask

    function automatic int ref_val(input int dt, input int sgn);
        int m;
        m = (dt >= 0 && dt <= 20) ? mag_ref[dt] : 0;
        return (sgn != 0) ? m : -m;
    endfunction

    function automatic int rr_pick(input logic [N_CH-1:0] v, input int p);
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (p + k) % N_CH;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic int dt_of(input int c);
        return int'((req_dt >> (c * DT_W)) & 32'hFF);
    endfunction

    function automatic int sign_of(input int c);
        return int'((req_sign >> c) & 4'h1);
    endfunction

    task automatic set_req(input int c, input int dt, input int sgn);
        logic [N_CH*DT_W-1:0] mask;
        mask     = (N_CH*DT_W)'(32'hFF) << (c * DT_W);
        req_dt   = (req_dt & ~mask) | ((N_CH*DT_W)'(dt & 255) << (c * DT_W));
        req_sign = (req_sign & ~(N_CH'(1) << c)) | (N_CH'(sgn & 1) << c);
    endtask

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic step();
        int    g;
        bit    stall;
        bit    adv;
        int    exp_ready;
        item_t it;
        @(negedge clk);
        stall     = s1_full && out_full && !rsp_ready;
        g         = stall ? -1 : rr_pick(req_valid, ptr_m);
        exp_ready = (g >= 0) ? (1 << g) : 0;
        check("req_ready", int'(req_ready), exp_ready);
        check("rsp_valid", int'(rsp_valid), int'(out_full));
        if (out_full && exp_q.size() > 0) begin
            check("rsp_ch", int'(rsp_ch), exp_q[0].ch);
            check("rsp_val", int'($signed(rsp_val)), exp_q[0].val);
        end
        if (rsp_valid && rsp_ready) begin
            last_ch        = int'(rsp_ch);
            last_val       = int'($signed(rsp_val));
            last_rsp_cycle = cycle;
            $display("cycle %0d rsp ch=%0d val=%0d", cycle, last_ch, last_val);
        end
        adv = !out_full || rsp_ready;
        if (out_full && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        out_full = adv ? s1_full : out_full;
        if (g >= 0) begin
            s1_full = 1'b1;
        end else if (adv) begin
            s1_full = 1'b0;
        end
        if (g >= 0) begin
            it.ch  = g;
            it.val = ref_val(dt_of(g), sign_of(g));
            exp_q.push_back(it);
            ptr_m          = (g + 1) % N_CH;
            last_acc_cycle = cycle;
            grant_log.push_back(g);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        req_valid = '1;
        #1;
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_ch", int'(rsp_ch), 0);
        check("rst_rsp_val", int'(rsp_val), 0);
        check("rst_req_ready", int'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_req_ready", int'(req_ready), 0);
        check("rst_hold_rsp_valid", int'(rsp_valid), 0);
        req_valid = '0;
        rst       = 1'b1;
        exp_q.delete();
        s1_full  = 1'b0;
        out_full = 1'b0;
        ptr_m    = 0;
    endtask

    initial begin
        mag_ref = '{0, 0, 329, 269, 220, 180, 148, 121, 99, 81, 66,
                    54, 44, 36, 29, 24, 20, 16, 13, 10, 9};
        vecs[0] = '{ch: 0, dt: 2,   sgn: 0, val: -329};
        vecs[1] = '{ch: 0, dt: 10,  sgn: 1, val: 66};
        vecs[2] = '{ch: 1, dt: 0,   sgn: 1, val: 0};
        vecs[3] = '{ch: 2, dt: 1,   sgn: 0, val: 0};
        vecs[4] = '{ch: 3, dt: 21,  sgn: 1, val: 0};
        vecs[5] = '{ch: 0, dt: 255, sgn: 0, val: 0};
        vecs[6] = '{ch: 1, dt: 20,  sgn: 1, val: 9};
        vecs[7] = '{ch: 2, dt: 20,  sgn: 0, val: -9};
        vecs[8] = '{ch: 3, dt: 5,   sgn: 1, val: 180};
        vecs[9] = '{ch: 1, dt: 12,  sgn: 0, val: -44};

        n_checks  = 0;
        n_errors  = 0;
        cycle     = 0;
        last_ch   = -1;
        last_val  = -1;
        last_rsp_cycle = -100;
        last_acc_cycle = 0;
        rst       = 1'b0;
        req_valid = '0;
        req_dt    = '0;
        req_sign  = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        apply_reset();

        // Directed single lookups with latency check.
        for (int i = 0; i < 10; i++) begin
            req_dt   = '0;
            req_sign = '0;
            set_req(vecs[i].ch, vecs[i].dt, vecs[i].sgn);
            req_valid = N_CH'(1) << vecs[i].ch;
            step();
            req_valid = '0;
            step();
            step();
            check("tbl_val", last_val, vecs[i].val);
            check("tbl_ch", last_ch, vecs[i].ch);
            check("tbl_latency", last_rsp_cycle - last_acc_cycle, 2);
        end

        // Round-robin with all channels requesting.
        apply_reset();
        for (int c = 0; c < N_CH; c++) set_req(c, 3 + c, 0);
        grant_log.delete();
        req_valid = '1;
        repeat (8) step();
        req_valid = '0;
        repeat (3) step();
        check("rr_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) check("rr_order", grant_log[i], i % N_CH);

        // Backpressure: two accepts then five stalled cycles.
        grant_log.delete();
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (7) step();
        check("bp_accepts", grant_log.size(), 2);
        check("bp_held_ch", int'(rsp_ch), 0);
        rsp_ready = 1'b1;
        repeat (4) step();
        req_valid = '0;
        repeat (3) step();
        check("bp_resume_grant", grant_log[2], 2);

        // Sparse fairness: only channels 1 and 3.
        grant_log.delete();
        req_valid = 4'b1010;
        repeat (8) step();
        req_valid = '0;
        repeat (3) step();
        check("sparse_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) begin
            check("sparse_member", int'(grant_log[i] == 1 || grant_log[i] == 3), 1);
            if (i > 0) check("sparse_alt", int'(grant_log[i] != grant_log[i-1]), 1);
        end

        // Mid-flight reset with both stages full.
        rsp_ready = 1'b0;
        req_valid = '1;
        step();
        step();
        step();
        check("mf_full_valid", int'(rsp_valid), 1);
        apply_reset();
        rsp_ready = 1'b1;
        repeat (4) step();
        grant_log.delete();
        req_valid = '1;
        step();
        req_valid = '0;
        repeat (3) step();
        check("mf_ptr_zero", grant_log[0], 0);

        // Random traffic against the scoreboard.
        for (int n = 0; n < 400; n++) begin
            req_valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 3) == 0) set_req(c, $urandom_range(0, 255), $urandom_range(0, 1));
                else set_req(c, $urandom_range(0, 23), $urandom_range(0, 1));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
